// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl
// Host-command sequencer between the UART byte streams and the register bank.
// It parses framed read/write requests from the RX stream, issues one register
// access per frame, and returns an ACK, read-data or NAK frame on the TX stream.
//
// Ports
//   clk              in   system clock
//   reset            in   synchronous active-low reset
//   from_uart_*      RX byte stream (data/valid/error in, ready out)
//   to_uart_*        TX byte stream (data/valid/error out, ready in)
//   reg_addr/wdata   register address / write data, held between strobes
//   reg_wr/reg_rd    one-cycle access strobes
//   reg_rdata/rvalid read return
//   busy             high whenever the sequencer is not idle
//   err_cnt          saturating count of aborted or NAKed frames
module uart_cmd_ctrl #(
  parameter int TIMEOUT_CYC = 100000,
  parameter int RD_WAIT     = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  from_uart_data,
  input  logic        from_uart_valid,
  input  logic        from_uart_error,
  output logic        from_uart_ready,
  output logic [7:0]  to_uart_data,
  output logic        to_uart_valid,
  output logic        to_uart_error,
  input  logic        to_uart_ready,
  output logic [7:0]  reg_addr,
  output logic [15:0] reg_wdata,
  output logic        reg_wr,
  output logic        reg_rd,
  input  logic [15:0] reg_rdata,
  input  logic        reg_rvalid,
  output logic        busy,
  output logic [7:0]  err_cnt
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam int RW_W = $clog2(RD_WAIT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [RW_W-1:0] RW_LAST = RW_W'(RD_WAIT - 1);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_CMD     = 4'd1,
    S_ADDR    = 4'd2,
    S_DH      = 4'd3,
    S_DL      = 4'd4,
    S_CHK     = 4'd5,
    S_EXEC_WR = 4'd6,
    S_EXEC_RD = 4'd7,
    S_WAIT_RD = 4'd8,
    S_TX      = 4'd9
  } state_t;

  // Checksum carried in the read response frame.
  function automatic logic [7:0] resp_chk(input logic [7:0] addr, input logic [15:0] data);
    return 8'h02 ^ addr ^ data[15:8] ^ data[7:0];
  endfunction

  state_t            r_state;
  state_t            w_state_nxt;
  logic [TO_W-1:0]   r_to_cnt;
  logic [RW_W-1:0]   r_rd_cnt;
  logic [7:0]        r_chk;
  logic              r_is_wr;
  logic [7:0]        r_addr;
  logic [7:0]        r_dh;
  logic [7:0]        r_dl;
  logic [47:0]       r_tx_buf;
  logic [2:0]        r_tx_cnt;

  logic w_rx_xfer, w_rx_bad, w_rx_ok, w_in_frame, w_to_hit, w_rd_hit, w_tx_xfer;
  logic w_tx_load, w_nak, w_abort, w_err_evt;
  logic w_rx_ready_nxt, w_busy_nxt, w_wr_nxt, w_rd_nxt, w_tx_valid_nxt;

  assign w_rx_xfer  = from_uart_valid & from_uart_ready;
  assign w_rx_bad   = w_rx_xfer & from_uart_error;
  assign w_rx_ok    = w_rx_xfer & ~from_uart_error;
  assign w_in_frame = r_state inside {S_CMD, S_ADDR, S_DH, S_DL, S_CHK};
  // A byte arriving in the expiry cycle wins over the timeout.
  assign w_to_hit   = (r_to_cnt == TO_LAST) & ~w_rx_xfer;
  assign w_rd_hit   = (r_rd_cnt == RW_LAST);
  assign w_tx_xfer  = to_uart_valid & to_uart_ready;

  // Every entry into TX other than after a write or a returned read is a NAK.
  assign w_tx_load  = (w_state_nxt == S_TX) && (r_state != S_TX);
  assign w_nak      = w_tx_load && (r_state != S_EXEC_WR) &&
                      !((r_state == S_WAIT_RD) && reg_rvalid);
  // The only way out of a frame state back to IDLE is an error byte or a timeout.
  assign w_abort    = w_in_frame && (w_state_nxt == S_IDLE);
  assign w_err_evt  = w_nak | w_abort;

  assign to_uart_data  = r_tx_buf[47:40];
  assign to_uart_error = 1'b0;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_rx_ok && (from_uart_data == 8'hA5)) w_state_nxt = S_CMD;
        else                                      w_state_nxt = S_IDLE;
      end
      S_CMD, S_ADDR, S_DH, S_DL, S_CHK: begin
        if (w_rx_bad || w_to_hit) begin
          w_state_nxt = S_IDLE;
        end else if (w_rx_ok) begin
          case (r_state)
            S_CMD:   w_state_nxt = ((from_uart_data == 8'h01) || (from_uart_data == 8'h02)) ? S_ADDR : S_TX;
            S_ADDR:  w_state_nxt = r_is_wr ? S_DH : S_CHK;
            S_DH:    w_state_nxt = S_DL;
            S_DL:    w_state_nxt = S_CHK;
            S_CHK:   w_state_nxt = (from_uart_data != r_chk) ? S_TX : (r_is_wr ? S_EXEC_WR : S_EXEC_RD);
            default: w_state_nxt = S_IDLE;
          endcase
        end else begin
          w_state_nxt = r_state;
        end
      end
      S_EXEC_WR: w_state_nxt = S_TX;
      S_EXEC_RD: w_state_nxt = S_WAIT_RD;
      S_WAIT_RD: begin
        // rvalid in the expiry cycle still counts as a successful read.
        if (reg_rvalid || w_rd_hit) w_state_nxt = S_TX;
        else                        w_state_nxt = S_WAIT_RD;
      end
      S_TX: begin
        if (w_tx_xfer && (r_tx_cnt == 3'd1)) w_state_nxt = S_IDLE;
        else                                 w_state_nxt = S_TX;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode from the next state, so the output flops track the state register.
  always_comb begin
    w_rx_ready_nxt = 1'b0;
    w_busy_nxt     = 1'b0;
    w_wr_nxt       = 1'b0;
    w_rd_nxt       = 1'b0;
    w_tx_valid_nxt = 1'b0;
    case (w_state_nxt)
      S_IDLE:                           w_rx_ready_nxt = 1'b1;
      S_CMD, S_ADDR, S_DH, S_DL, S_CHK: begin
        w_rx_ready_nxt = 1'b1;
        w_busy_nxt     = 1'b1;
      end
      S_EXEC_WR: begin
        w_wr_nxt   = 1'b1;
        w_busy_nxt = 1'b1;
      end
      S_EXEC_RD: begin
        w_rd_nxt   = 1'b1;
        w_busy_nxt = 1'b1;
      end
      S_WAIT_RD:                        w_busy_nxt = 1'b1;
      S_TX: begin
        w_tx_valid_nxt = 1'b1;
        w_busy_nxt     = 1'b1;
      end
      default: w_busy_nxt = 1'b0;
    endcase
  end

  // Output flops for handshake, strobe and status signals.
  always_ff @(posedge clk) begin
    if (!reset) begin
      from_uart_ready <= 1'b0;
      to_uart_valid   <= 1'b0;
      reg_wr          <= 1'b0;
      reg_rd          <= 1'b0;
      busy            <= 1'b0;
    end else begin
      from_uart_ready <= w_rx_ready_nxt;
      to_uart_valid   <= w_tx_valid_nxt;
      reg_wr          <= w_wr_nxt;
      reg_rd          <= w_rd_nxt;
      busy            <= w_busy_nxt;
    end
  end

  // Frame capture, timers, register-bus latches, response buffer and error count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_to_cnt  <= '0;
      r_rd_cnt  <= '0;
      r_chk     <= 8'h00;
      r_is_wr   <= 1'b0;
      r_addr    <= 8'h00;
      r_dh      <= 8'h00;
      r_dl      <= 8'h00;
      r_tx_buf  <= 48'h0;
      r_tx_cnt  <= 3'd0;
      reg_addr  <= 8'h00;
      reg_wdata <= 16'h0000;
      err_cnt   <= 8'h00;
    end else begin
      if (w_in_frame && !w_rx_xfer) r_to_cnt <= r_to_cnt + TO_W'(1);
      else                          r_to_cnt <= '0;

      if (r_state == S_WAIT_RD) r_rd_cnt <= r_rd_cnt + RW_W'(1);
      else                      r_rd_cnt <= '0;

      // Running XOR of every byte after SYNC, excluding the CHK byte itself.
      if (r_state == S_IDLE) begin
        r_chk <= 8'h00;
      end else if (w_rx_ok && (r_state inside {S_CMD, S_ADDR, S_DH, S_DL})) begin
        r_chk <= r_chk ^ from_uart_data;
      end else begin
        r_chk <= r_chk;
      end

      if (w_rx_ok) begin
        case (r_state)
          S_CMD:   r_is_wr <= (from_uart_data == 8'h01);
          S_ADDR:  r_addr  <= from_uart_data;
          S_DH:    r_dh    <= from_uart_data;
          S_DL:    r_dl    <= from_uart_data;
          default: r_addr  <= r_addr;
        endcase
      end

      // Bus address/data change only when a new access is launched.
      if ((r_state == S_CHK) && (w_state_nxt == S_EXEC_WR)) begin
        reg_addr  <= r_addr;
        reg_wdata <= {r_dh, r_dl};
      end else if ((r_state == S_CHK) && (w_state_nxt == S_EXEC_RD)) begin
        reg_addr  <= r_addr;
      end else begin
        reg_addr  <= reg_addr;
      end

      // Response bytes are queued MSB-first and shifted out; zeros fill behind.
      if (w_tx_load) begin
        case (r_state)
          S_EXEC_WR: begin
            r_tx_buf <= {8'h06, reg_addr, 32'h0};
            r_tx_cnt <= 3'd2;
          end
          S_WAIT_RD: begin
            if (reg_rvalid) begin
              r_tx_buf <= {8'hA5, 8'h02, reg_addr, reg_rdata, resp_chk(reg_addr, reg_rdata)};
              r_tx_cnt <= 3'd6;
            end else begin
              r_tx_buf <= {8'h15, 8'h03, 32'h0};
              r_tx_cnt <= 3'd2;
            end
          end
          S_CHK: begin
            r_tx_buf <= {8'h15, 8'h01, 32'h0};
            r_tx_cnt <= 3'd2;
          end
          default: begin
            r_tx_buf <= {8'h15, 8'h02, 32'h0};
            r_tx_cnt <= 3'd2;
          end
        endcase
      end else if ((r_state == S_TX) && w_tx_xfer) begin
        r_tx_buf <= {r_tx_buf[39:0], 8'h00};
        r_tx_cnt <= r_tx_cnt - 3'd1;
      end else begin
        r_tx_buf <= r_tx_buf;
      end

      if (w_err_evt && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
      else                                 err_cnt <= err_cnt;
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
module tb_uart_cmd_ctrl;

  localparam int TO_CYC = 50;
  localparam int RDW    = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  from_uart_data;
  logic        from_uart_valid;
  logic        from_uart_error;
  logic        from_uart_ready;
  logic [7:0]  to_uart_data;
  logic        to_uart_valid;
  logic        to_uart_error;
  logic        to_uart_ready;
  logic [7:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic        reg_wr;
  logic        reg_rd;
  logic [15:0] reg_rdata;
  logic        reg_rvalid;
  logic        busy;
  logic [7:0]  err_cnt;

  always #5 clk = ~clk;

  uart_cmd_ctrl #(.TIMEOUT_CYC(TO_CYC), .RD_WAIT(RDW)) dut (
    .clk(clk), .reset(reset),
    .from_uart_data(from_uart_data), .from_uart_valid(from_uart_valid),
    .from_uart_error(from_uart_error), .from_uart_ready(from_uart_ready),
    .to_uart_data(to_uart_data), .to_uart_valid(to_uart_valid),
    .to_uart_error(to_uart_error), .to_uart_ready(to_uart_ready),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr(reg_wr), .reg_rd(reg_rd),
    .reg_rdata(reg_rdata), .reg_rvalid(reg_rvalid), .busy(busy), .err_cnt(err_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Frame bytes and response bytes are right-aligned, first byte most significant.
  typedef struct {
    logic [79:0] rx;
    int          nrx;
    logic [9:0]  emask;
    int          rv_dly;   // cycles from reg_rd to reg_rvalid, 0 = never
    logic [15:0] rdata;
    logic [47:0] tx;
    int          ntx;
    int          lat;      // cycle of first TX valid after last RX byte, -1 = n/a
    int          nwr;
    int          nrd;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [7:0]  err;
  } vec_t;

  function automatic vec_t mk(input logic [79:0] rx, input int nrx, input logic [9:0] emask,
                              input int rv_dly, input logic [15:0] rdata,
                              input logic [47:0] tx, input int ntx, input int lat,
                              input int nwr, input int nrd, input logic [7:0] addr,
                              input logic [15:0] wdata, input logic [7:0] err);
    vec_t v;
    v.rx = rx; v.nrx = nrx; v.emask = emask; v.rv_dly = rv_dly; v.rdata = rdata;
    v.tx = tx; v.ntx = ntx; v.lat = lat; v.nwr = nwr; v.nrd = nrd;
    v.addr = addr; v.wdata = wdata; v.err = err;
    return v;
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic e);
    int n = 0;
    from_uart_data  = b;
    from_uart_valid = 1'b1;
    from_uart_error = e;
    while (!from_uart_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rx_accept", 32'(from_uart_ready), 32'd1);
    @(negedge clk);
    from_uart_valid = 1'b0;
    from_uart_error = 1'b0;
  endtask

  // Sends a frame, services the register bus and collects the response.
  task automatic run_vec(input string name, input vec_t v, input int hold_idx, input int hold_n);
    logic [7:0]  got [8];
    int          ngot = 0;
    int          nwr = 0;
    int          nrd = 0;
    int          rd_c = -1;
    int          first_c = -1;
    int          hold_left = hold_n;
    logic [7:0]  cap_addr = 8'h00;
    logic [15:0] cap_wd = 16'h0000;
    bit          done = 1'b0;
    for (int k = 0; k < 8; k++) got[k] = 8'h00;
    for (int i = 0; i < v.nrx; i++) send_byte(v.rx[8*(v.nrx-1-i) +: 8], v.emask[i]);
    for (int c = 0; c < 100 && !done; c++) begin
      if (reg_wr) begin nwr++; cap_addr = reg_addr; cap_wd = reg_wdata; end
      if (reg_rd) begin nrd++; cap_addr = reg_addr; rd_c = c; end
      reg_rvalid = (rd_c >= 0) && (v.rv_dly > 0) && (c == rd_c + v.rv_dly);
      reg_rdata  = reg_rvalid ? v.rdata : ~v.rdata;
      if (to_uart_valid && first_c < 0) first_c = c;
      if (to_uart_valid && ngot == hold_idx && hold_left > 0) begin
        to_uart_ready = 1'b0;
        hold_left--;
        chk({name, "_hold_data"}, 32'(to_uart_data), 32'(v.tx[8*(v.ntx-1-hold_idx) +: 8]));
        chk({name, "_hold_rx_ready"}, 32'(from_uart_ready), 32'd0);
      end else begin
        to_uart_ready = 1'b1;
        if (to_uart_valid) begin
          if (ngot < 8) got[ngot] = to_uart_data;
          ngot++;
        end
      end
      if (!busy) done = 1'b1;
      else @(negedge clk);
    end
    reg_rvalid    = 1'b0;
    to_uart_ready = 1'b1;
    chk({name, "_idle"}, 32'(busy), 32'd0);
    chk({name, "_ntx"}, 32'(ngot), 32'(v.ntx));
    for (int k = 0; k < v.ntx && k < 6; k++)
      chk({name, "_tx_byte"}, 32'(got[k]), 32'(v.tx[8*(v.ntx-1-k) +: 8]));
    chk({name, "_nwr"}, 32'(nwr), 32'(v.nwr));
    chk({name, "_nrd"}, 32'(nrd), 32'(v.nrd));
    if (v.nwr + v.nrd > 0) chk({name, "_addr"}, 32'(cap_addr), 32'(v.addr));
    if (v.nwr > 0) chk({name, "_wdata"}, 32'(cap_wd), 32'(v.wdata));
    if (v.lat >= 0) chk({name, "_latency"}, 32'(first_c), 32'(v.lat));
    chk({name, "_err_cnt"}, 32'(err_cnt), 32'(v.err));
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_rx_ready"}, 32'(from_uart_ready), 32'd0);
    chk({name, "_tx_valid"}, 32'(to_uart_valid), 32'd0);
    chk({name, "_tx_data"}, 32'(to_uart_data), 32'd0);
    chk({name, "_tx_error"}, 32'(to_uart_error), 32'd0);
    chk({name, "_wr"}, 32'(reg_wr), 32'd0);
    chk({name, "_rd"}, 32'(reg_rd), 32'd0);
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_err_cnt"}, 32'(err_cnt), 32'd0);
  endtask

  vec_t tbl [10];
  vec_t wr_ok;

  initial begin
    tbl[0] = mk(80'hA5_01_10_12_34_37, 6, 10'b0, 0, 16'h0000, 48'h06_10, 2, 1, 1, 0, 8'h10, 16'h1234, 8'd0);
    tbl[1] = mk(80'hA5_02_20_22, 4, 10'b0, 3, 16'hBEEF, 48'hA5_02_20_BE_EF_73, 6, 4, 0, 1, 8'h20, 16'h0000, 8'd0);
    tbl[2] = mk(80'hA5_01_10_12_34_00, 6, 10'b0, 0, 16'h0000, 48'h15_01, 2, 0, 0, 0, 8'h00, 16'h0000, 8'd1);
    tbl[3] = mk(80'h00_FF_5A_A5_01_10_12_34_37, 9, 10'b0, 0, 16'h0000, 48'h06_10, 2, 1, 1, 0, 8'h10, 16'h1234, 8'd1);
    tbl[4] = mk(80'hA5_07, 2, 10'b0, 0, 16'h0000, 48'h15_02, 2, 0, 0, 0, 8'h00, 16'h0000, 8'd2);
    tbl[5] = mk(80'hA5_01_33_AB_CD_54, 6, 10'b0, 0, 16'h0000, 48'h06_33, 2, 1, 1, 0, 8'h33, 16'hABCD, 8'd2);
    tbl[6] = mk(80'hA5_02_40_42, 4, 10'b0, 0, 16'h0000, 48'h15_03, 2, 9, 0, 1, 8'h40, 16'h0000, 8'd3);
    tbl[7] = mk(80'hA5_01_10, 3, 10'b0000000100, 0, 16'h0000, 48'h0, 0, -1, 0, 0, 8'h00, 16'h0000, 8'd4);
    tbl[8] = mk(80'hA5_02_7F_7D, 4, 10'b0, 1, 16'h0102, 48'hA5_02_7F_01_02_7E, 6, 2, 0, 1, 8'h7F, 16'h0000, 8'd4);
    tbl[9] = mk(80'hA5_01_A5_A5_00_01, 6, 10'b0, 0, 16'h0000, 48'h06_A5, 2, 1, 1, 0, 8'hA5, 16'hA500, 8'd4);

    reset = 1'b0; from_uart_data = 8'h00; from_uart_valid = 1'b0; from_uart_error = 1'b0;
    to_uart_ready = 1'b1; reg_rdata = 16'h0000; reg_rvalid = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    chk("reset_addr", 32'(reg_addr), 32'd0);
    chk("reset_wdata", 32'(reg_wdata), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(from_uart_ready), 32'd1);

    for (int i = 0; i < 10; i++) run_vec($sformatf("vec%0d", i), tbl[i], -1, 0);

    // Inter-byte timeout inside a frame: silent abort, error counted.
    begin
      int nv = 0;
      send_byte(8'hA5, 1'b0);
      send_byte(8'h01, 1'b0);
      repeat (60) begin
        @(negedge clk);
        if (to_uart_valid) nv++;
      end
      chk("timeout_no_resp", 32'(nv), 32'd0);
      chk("timeout_busy", 32'(busy), 32'd0);
      chk("timeout_err_cnt", 32'(err_cnt), 32'd5);
    end
    wr_ok = mk(80'hA5_01_10_12_34_37, 6, 10'b0, 0, 16'h0000, 48'h06_10, 2, 1, 1, 0, 8'h10, 16'h1234, 8'd5);
    run_vec("after_timeout", wr_ok, -1, 0);

    // Read response with byte 3 backpressured for 10 cycles.
    run_vec("backpressure",
            mk(80'hA5_02_20_22, 4, 10'b0, 3, 16'hBEEF, 48'hA5_02_20_BE_EF_73, 6, 4, 0, 1, 8'h20, 16'h0000, 8'd5),
            2, 10);

    // Reset while a NAK response is stalled on the TX side.
    send_byte(8'hA5, 1'b0); send_byte(8'h01, 1'b0); send_byte(8'h10, 1'b0);
    send_byte(8'h12, 1'b0); send_byte(8'h34, 1'b0); send_byte(8'h00, 1'b0);
    to_uart_ready = 1'b0;
    @(negedge clk);
    chk("midrst_tx_valid", 32'(to_uart_valid), 32'd1);
    chk("midrst_tx_data", 32'(to_uart_data), 32'h15);
    reset = 1'b0;
    @(negedge clk);
    chk_all_zero("midrst");
    reset = 1'b1;
    to_uart_ready = 1'b1;
    @(negedge clk);
    chk("midrst_ready_back", 32'(from_uart_ready), 32'd1);
    wr_ok.err = 8'd0;
    run_vec("after_reset", wr_ok, -1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
